// File: rtl/uart_dbg_ctrl.sv
// UART debug command sequencer: parses 'W'/'R' commands from the receiver,
// runs one 32-bit debug bus transaction, and streams the response back out.
module uart_dbg_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 100000,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  input  logic        rx_framing_error,
  output logic        start_rcv,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_req,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        cmd_error
);

  localparam int unsigned TW = $clog2(IDLE_TIMEOUT);
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS, RESP, NAK} state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [TW-1:0] tmo;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          is_write;

  assign bus_wen   = is_write;
  assign bus_addr  = addr;
  assign bus_wdata = wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tmo       <= '0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      is_write  <= 1'b0;
      start_rcv <= 1'b1;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      bus_req   <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      cmd_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_framing_error) begin
            state     <= NAK;
            cmd_error <= 1'b1;
            start_rcv <= 1'b0;
          end else if (rx_data_ready) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              is_write <= (rx_data == OP_WRITE);
              cnt      <= '0;
              tmo      <= '0;
              state    <= GET_ADDR;
            end else begin
              state     <= NAK;
              cmd_error <= 1'b1;
              start_rcv <= 1'b0;
            end
          end
        end

        GET_ADDR, GET_DATA: begin
          // Framing error beats a coincident byte; a byte beats timeout expiry.
          if (rx_framing_error) begin
            state     <= NAK;
            cmd_error <= 1'b1;
            start_rcv <= 1'b0;
          end else if (rx_data_ready) begin
            tmo <= '0;
            cnt <= cnt + 2'd1;
            if (state == GET_ADDR) addr  <= {addr[23:0], rx_data};
            else                   wdata <= {wdata[23:0], rx_data};
            if (cnt == 2'd3) begin
              if (state == GET_ADDR && is_write) begin
                state <= GET_DATA;
              end else begin
                state     <= BUS;
                bus_req   <= 1'b1;
                start_rcv <= 1'b0;
              end
            end
          end else if (tmo == TW'(IDLE_TIMEOUT - 1)) begin
            state     <= IDLE;
            cmd_error <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        BUS: begin
          if (bus_ack) begin
            rdata   <= bus_rdata;
            bus_req <= 1'b0;
            cnt     <= '0;
            state   <= RESP;
          end
        end

        RESP: begin
          if (!tx_start && !tx_busy) begin
            tx_start <= 1'b1;
            cnt      <= cnt + 2'd1;
            if (is_write) begin
              tx_data   <= ACK_BYTE;
              state     <= IDLE;
              start_rcv <= 1'b1;
            end else begin
              tx_data <= rdata[31:24];
              rdata   <= {rdata[23:0], 8'h00};
              if (cnt == 2'd3) begin
                state     <= IDLE;
                start_rcv <= 1'b1;
              end
            end
          end
        end

        NAK: begin
          if (!tx_start && !tx_busy) begin
            tx_start  <= 1'b1;
            tx_data   <= NAK_BYTE;
            state     <= IDLE;
            start_rcv <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
